// File: rtl/l2_read_responder.sv
// l2_read_responder
// L2-side responder for the L1 instruction-read path: a 64-line x 128-bit,
// direct-mapped, read-only cache that fetches missing lines from main
// memory and returns both the requested word and the full line to L1.
// Optional build macro: L2_PERF_CNT_EN adds saturating hit_cnt/miss_cnt ports.
module l2_read_responder (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         L1_read,
    input  logic [29:0]  L1_addr,
    output logic [31:0]  L1_rdata,
    output logic [127:0] L1_line,
    output logic         L1_ready,
    output logic         mem_read,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_READ,
        RESPOND
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    // Captured request address; governs the whole transaction
    logic [29:0]  r_addr;

    // Line storage
    logic [63:0]  r_valid;
    logic [21:0]  r_tag  [0:63];
    logic [127:0] r_data [0:63];

    // Response and memory-request registers
    logic [31:0]  r_rdata;
    logic [127:0] r_line;
    logic         r_ready;
    logic         r_mem_read;
    logic [27:0]  r_mem_addr;

    logic [5:0]   w_index;
    logic [21:0]  w_tag;
    logic [6:0]   w_word_lsb;
    logic [127:0] w_stored_line;
    logic         w_lookup;
    logic         w_hit;
    logic         w_fill;

    assign w_index       = r_addr[7:2];
    assign w_tag         = r_addr[29:8];
    assign w_word_lsb    = {r_addr[1:0], 5'b0_0000};
    assign w_stored_line = r_data[w_index];
    assign w_lookup      = (r_state == LOOKUP);
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A memory response only counts once the request is actually visible
    assign w_fill        = (r_state == MEM_READ) && r_mem_read && mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (L1_read) w_next_state = LOOKUP;
            LOOKUP:   w_next_state = w_hit ? RESPOND : MEM_READ;
            MEM_READ: if (w_fill) w_next_state = RESPOND;
            RESPOND:  w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Request address capture, only while idle
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_addr <= '0;
        end else if ((r_state == IDLE) && L1_read) begin
            r_addr <= L1_addr;
        end
    end

    // Memory line request: raised one cycle into MEM_READ, dropped on the response
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else if (w_fill) begin
            r_mem_read <= 1'b0;
        end else if ((r_state == MEM_READ) && !r_mem_read) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= r_addr[29:2];
        end
    end

    // Response registers and one-cycle ready strobe.
    // The hit path enters RESPOND with the strobe low and raises it on the way
    // out; the fill path raises it on entry and RESPOND drops it again.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_line  <= '0;
        end else begin
            r_ready <= 1'b0;
            if (w_lookup && w_hit) begin
                r_rdata <= w_stored_line[w_word_lsb +: 32];
                r_line  <= w_stored_line;
            end else if (w_fill) begin
                r_rdata <= mem_rdata[w_word_lsb +: 32];
                r_line  <= mem_rdata;
                r_ready <= 1'b1;
            end else if (r_state == RESPOND) begin
                r_ready <= !r_ready;
            end
        end
    end

    // Valid bits: cleared by reset, set when a line is filled
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    // Tag and data storage, replaced unconditionally on a fill
    always_ff @(posedge clk) begin
        if (w_fill && !proc_reset) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= mem_rdata;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating lookup hit/miss counters
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_lookup) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign L1_rdata = r_rdata;
    assign L1_line  = r_line;
    assign L1_ready = r_ready;
    assign mem_read = r_mem_read;
    assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_l2_read_responder.sv
// Self-checking bench for l2_read_responder: table-driven directed reads,
// hand-written multi-cycle sequences, and random reads against a
// direct-mapped cache reference model.
module tb_l2_read_responder;

    logic         clk;
    logic         proc_reset;
    logic         L1_read;
    logic [29:0]  L1_addr;
    logic [31:0]  L1_rdata;
    logic [127:0] L1_line;
    logic         L1_ready;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    l2_read_responder dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .L1_read    (L1_read),
        .L1_addr    (L1_addr),
        .L1_rdata   (L1_rdata),
        .L1_line    (L1_line),
        .L1_ready   (L1_ready),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: which tag each direct-mapped set holds
    bit          mdl_valid [64];
    logic [21:0] mdl_tag   [64];
    int          mdl_hits   = 0;
    int          mdl_misses = 0;

    typedef struct {
        logic [29:0] addr;
        int          lat;
        bit          exp_hit;
        logic [31:0] exp_word;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: line 0x41 holds the 1111/2222/3333/4444 pattern,
    // every other line encodes its own address and word number.
    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        logic [31:0]  m;
        logic [1:0]   wb;
        l = '0;
        for (int w = 0; w < 4; w++) begin
            m  = 32'(w + 1);
            wb = 2'(w);
            if (la == 28'h000_0041) l[32*w +: 32] = 32'h1111_1111 * m;
            else                    l[32*w +: 32] = {wb, 2'b01, la};
        end
        return l;
    endfunction

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [127:0] l;
        l = mem_line(a[29:2]);
        return l[32*int'(a[1:0]) +: 32];
    endfunction

    // Predict hit/miss for an address and update the model accordingly
    function automatic bit model_access(input logic [29:0] a);
        int unsigned idx;
        bit          h;
        idx = int'(a[7:2]);
        h   = mdl_valid[idx] && (mdl_tag[idx] == a[29:8]);
        if (h) begin
            mdl_hits++;
        end else begin
            mdl_misses++;
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = a[29:8];
        end
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
        mdl_hits   = 0;
        mdl_misses = 0;
    endtask

    // One read transaction; the bench also plays the memory with a given latency.
    // Called and returns at a negedge.
    task automatic do_read(input logic [29:0] addr, input int lat, input bit exp_hit,
                           input logic [31:0] exp_word, input string nm);
        int           mr_k;
        int           rdy_k;
        bit           served;
        bit           addr_bad;
        logic [127:0] exp_line;
        mr_k     = -1;
        rdy_k    = -1;
        served   = 1'b0;
        addr_bad = 1'b0;
        exp_line = mem_line(addr[29:2]);
        L1_read  = 1'b1;
        L1_addr  = addr;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                L1_read = 1'b0;
                L1_addr = 30'h3FFF_FFFF;
            end
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_read) begin
                if (mr_k < 0) mr_k = k;
                if (mem_addr !== addr[29:2]) addr_bad = 1'b1;
            end
            if (rdy_k >= 0) begin
                chk({nm, " ready_one_cycle"}, 128'(L1_ready), 128'(1'b0));
                chk({nm, " rdata_held"}, 128'(L1_rdata), 128'(exp_word));
                break;
            end
            if (L1_ready) begin
                rdy_k = k;
                chk({nm, " rdata"}, 128'(L1_rdata), 128'(exp_word));
                chk({nm, " line"}, L1_line, exp_line);
                chk({nm, " mem_read_low_at_ready"}, 128'(mem_read), 128'(1'b0));
            end
            if ((mr_k >= 0) && !served && (k - mr_k == lat)) begin
                mem_ready = 1'b1;
                mem_rdata = exp_line;
                served    = 1'b1;
            end
        end
        mem_ready = 1'b0;
        L1_read   = 1'b0;
        if (exp_hit) begin
            chk({nm, " no_mem_read"}, 128'(mr_k), 128'(-1));
            chk({nm, " hit_latency"}, 128'(rdy_k), 128'(2));
        end else begin
            chk({nm, " mem_read_rise"}, 128'(mr_k), 128'(2));
            chk({nm, " miss_latency"}, 128'(rdy_k), 128'(2 + lat + 1));
            chk({nm, " mem_addr"}, 128'(addr_bad), 128'(1'b0));
        end
    endtask

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{30'h0000_0105, 5, 1'b0, 32'h2222_2222};
        vecs[1] = '{30'h0000_0107, 0, 1'b1, 32'h4444_4444};
        vecs[2] = '{30'h0000_0205, 2, 1'b0, 32'h5000_0081};
        vecs[3] = '{30'h0000_0105, 1, 1'b0, 32'h2222_2222};
        vecs[4] = '{30'h0000_0104, 0, 1'b1, 32'h1111_1111};
        vecs[5] = '{30'h0000_0106, 3, 1'b1, 32'h3333_3333};

        proc_reset = 1'b1;
        L1_read    = 1'b0;
        L1_addr    = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset L1_ready", 128'(L1_ready), 128'(1'b0));
        chk("reset L1_rdata", 128'(L1_rdata), 128'(32'h0));
        chk("reset L1_line", L1_line, 128'h0);
        chk("reset mem_read", 128'(mem_read), 128'(1'b0));
        chk("reset mem_addr", 128'(mem_addr), 128'(28'h0));
        proc_reset = 1'b0;
        @(negedge clk);

        // Directed table: cold miss, hit, conflict refetch, re-miss, hits
        for (int i = 0; i < 6; i++) begin
            void'(model_access(vecs[i].addr));
            do_read(vecs[i].addr, vecs[i].lat, vecs[i].exp_hit, vecs[i].exp_word,
                    $sformatf("vec%0d", i));
        end

        // Back-to-back hits with L1_read held high: one response every 3 cycles
        begin
            logic [8:0] mask;
            mask    = '0;
            L1_read = 1'b1;
            L1_addr = 30'h0000_0104;
            @(posedge clk);
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                mask[k] = L1_ready;
                if (k == 8) L1_read = 1'b0;
            end
            @(negedge clk);
            chk("b2b ready_pattern", 128'(mask), 128'(9'b1_0010_0100));
            chk("b2b rdata", 128'(L1_rdata), 128'(32'h1111_1111));
            for (int i = 0; i < 3; i++) void'(model_access(30'h0000_0104));
        end

        // Random reads over a few sets and tags to mix hits, misses and evictions
        for (int i = 0; i < 60; i++) begin
            logic [21:0] t;
            logic [5:0]  ix;
            logic [1:0]  off;
            logic [29:0] a;
            bit          h;
            case ($urandom_range(0, 2))
                0:       t = 22'h00_0000;
                1:       t = 22'h00_0001;
                default: t = 22'h00_03A5;
            endcase
            case ($urandom_range(0, 3))
                0:       ix = 6'd0;
                1:       ix = 6'd1;
                2:       ix = 6'd2;
                default: ix = 6'd63;
            endcase
            off = 2'($urandom_range(0, 3));
            a   = {t, ix, off};
            h   = model_access(a);
            do_read(a, int'($urandom_range(0, 4)), h, mem_word(a), $sformatf("rnd%0d", i));
        end

`ifdef L2_PERF_CNT_EN
        chk("perf hit_cnt", 128'(hit_cnt), 128'(mdl_hits));
        chk("perf miss_cnt", 128'(miss_cnt), 128'(mdl_misses));
`endif

        // Reset during MEM_READ, then a late memory response that must be ignored
        begin
            bit seen;
            bit bad_ready;
            bit bad_mreq;
            seen      = 1'b0;
            bad_ready = 1'b0;
            bad_mreq  = 1'b0;
            L1_read   = 1'b1;
            L1_addr   = 30'h0001_2345;
            @(posedge clk);
            @(negedge clk);
            L1_read = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (mem_read) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("rst_mid mem_read_seen", 128'(seen), 128'(1'b1));
            @(negedge clk);
            proc_reset = 1'b1;
            @(negedge clk);
            chk("rst_mid mem_read_dropped", 128'(mem_read), 128'(1'b0));
            chk("rst_mid no_ready", 128'(L1_ready), 128'(1'b0));
            proc_reset = 1'b0;
            mem_ready  = 1'b1;
            mem_rdata  = mem_line(28'h000_48D1);
            @(negedge clk);
            mem_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (L1_ready) bad_ready = 1'b1;
                if (mem_read) bad_mreq  = 1'b1;
                @(negedge clk);
            end
            chk("rst_mid late_resp_ignored", 128'(bad_ready), 128'(1'b0));
            chk("rst_mid stays_idle", 128'(bad_mreq), 128'(1'b0));
            model_clear();
`ifdef L2_PERF_CNT_EN
            chk("perf hit_cnt_cleared", 128'(hit_cnt), 128'(32'h0));
            chk("perf miss_cnt_cleared", 128'(miss_cnt), 128'(32'h0));
`endif
        end

        // Previously cached line and the aborted line both miss after reset
        begin
            bit h;
            h = model_access(30'h0000_0104);
            do_read(30'h0000_0104, 1, h, 32'h1111_1111, "post_rst_a");
            h = model_access(30'h0001_2345);
            do_read(30'h0001_2345, 2, h, mem_word(30'h0001_2345), "post_rst_b");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_read_responder.md
# l2_read_responder

L2-side responder for the L1 instruction-read interface. It accepts single-word read requests from the L1 read cache and returns both the requested 32-bit word and the full 128-bit line so the L1 can fill. Internally it is a 64-line, direct-mapped, read-only L2 that fetches missing lines from main memory over a blocking request/ready interface. It sits between the L1 read cache and the memory model in the instruction path.

## Interface

Parameters:
- none; geometry is fixed at 64 lines × 4 words. Address bits: tag = L1_addr[29:8] (22 b), index = L1_addr[7:2] (6 b), word offset = L1_addr[1:0].

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- proc_reset  input  1  reset, synchronous, active-high
- L1_read  input  1  read request from L1
- L1_addr  input  30  word address of request
- L1_rdata  output  32  requested word, valid while L1_ready=1
- L1_line  output  128  full line containing the word, valid while L1_ready=1; word w occupies bits [32w+31:32w]
- L1_ready  output  1  one-cycle response strobe
- mem_read  output  1  line fetch request to memory
- mem_addr  output  28  line address (captured L1_addr[29:2])
- mem_rdata  input  128  line from memory, valid while mem_ready=1
- mem_ready  input  1  memory response strobe
- hit_cnt  output  32  present only with L2_PERF_CNT_EN
- miss_cnt  output  32  present only with L2_PERF_CNT_EN

## Operation

- Storage per line: valid (1), tag (22), data (128). No dirty bit; block never writes memory.
- States: IDLE, LOOKUP, MEM_READ, RESPOND.
- IDLE: if L1_read=1, capture L1_addr into addr_r → LOOKUP. Else stay.
- LOOKUP: index with addr_r. valid && tag match → hit: load response registers (word select by addr_r[1:0], line) → RESPOND. Otherwise miss → MEM_READ.
- MEM_READ: mem_read=1, mem_addr=addr_r[29:2], held steady. On mem_ready=1: write mem_rdata, tag, valid=1 into line addr_r[7:2]; load response registers from mem_rdata → RESPOND.
- RESPOND: L1_ready=1, L1_rdata/L1_line driven from response registers → IDLE.
- Miss replaces the indexed line unconditionally (direct-mapped).
- L1_read and L1_addr are ignored outside IDLE; captured addr_r governs the whole transaction.
- L1_read high in the cycle after RESPOND (back in IDLE) is a new request; L1 must deassert after L1_ready if it wants no re-read.
- mem_ready while not in MEM_READ is ignored.

## Timing

- All outputs registered/state-decoded; no combinational path input→output.
- Reset values: L1_ready=0, L1_rdata=0, L1_line=0, mem_read=0, mem_addr=0, state=IDLE, all valid bits=0; counters=0.
- Hit latency: L1_read sampled at edge N → L1_ready high in cycle after edge N+2, exactly one cycle.
- Miss latency: mem_read rises after edge N+2; if mem_ready is sampled at edge M, L1_ready high in the cycle after edge M, one cycle; mem_read falls at edge M.
- L1_rdata/L1_line are held at last response value after L1_ready drops (stable, not zeroed).
- proc_reset has priority in any state: at the next edge state=IDLE, mem_read=0, L1_ready=0, all lines invalidated; any in-flight memory response is discarded.
- Back-to-back: fastest request rate is one per 3 cycles on hits.

## Configuration

- L2_PERF_CNT_EN defined: hit_cnt and miss_cnt ports exist; hit_cnt increments on each LOOKUP hit, miss_cnt on each LOOKUP miss; both saturate at 32'hFFFF_FFFF; cleared by proc_reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan

- Reset then cold read L1_addr=30'h0000_0105 with memory returning line 128'h4444..._3333..._2222..._1111... after 5 cycles → mem_read high, mem_addr=28'h0000041; L1_ready one cycle, L1_rdata=32'h2222_2222, L1_line equals memory line.
- Repeat read of 30'h0000_0107 → no mem_read; L1_ready exactly 2 cycles after request edge; L1_rdata=word 3 (32'h4444_4444).
- Conflict: read 30'h0000_0105 then 30'h0000_0205 (same index 1, new tag) → second read misses and refetches; re-read of 30'h0000_0105 misses again.
- L1_addr changed to 30'h3FFF_FFFF during MEM_READ → mem_addr stays 28'h0000041, response for original address.
- proc_reset asserted mid-MEM_READ, then late mem_ready → mem_read=0 next cycle, no L1_ready, next read of same address misses.
- With L2_PERF_CNT_EN: sequence miss, hit, hit, miss → hit_cnt=2, miss_cnt=2; after proc_reset both 0.
